// File: rtl/mapper_bank_engine.sv
// Generic MBC-style bank-switching mapper: cart register decode, ROM/RAM address mapping,
// and an optional two-word savestate sequencer enabled by defining MAPPER_SAVESTATE_EN.
module mapper_bank_engine #(
    parameter int ROM_BANK_BITS = 9,
    parameter int RAM_BANK_BITS = 4,
    parameter int ZERO_REMAP    = 1
) (
    input  logic                       clk_sys,
    input  logic                       reset_n,
    input  logic                       ce_cpu,
    input  logic                       enable,
    input  logic [14:0]                cart_addr,
    input  logic                       cart_a15,
    input  logic                       cart_wr,
    input  logic [7:0]                 cart_di,
    input  logic                       has_ram,
    input  logic [ROM_BANK_BITS-1:0]   rom_mask,
    input  logic [RAM_BANK_BITS-1:0]   ram_mask,
    output logic [ROM_BANK_BITS+13:0]  mbc_addr,
    output logic [RAM_BANK_BITS+12:0]  cram_addr,
    output logic                       ram_enabled,
    input  logic                       ss_req,
    input  logic                       ss_wr,
    input  logic [15:0]                ss_data,
    output logic [15:0]                ss_back,
    output logic                       ss_valid,
    output logic                       ss_busy
);

    logic [ROM_BANK_BITS-1:0] rom_bank, rom_bank_w, rom_bank_nxt, rom_eff, rom_sel;
    logic [RAM_BANK_BITS-1:0] ram_bank, ram_bank_w, ram_bank_nxt;
    logic                     ram_en, ram_en_w, ram_en_nxt;
    logic                     mode, mode_w, mode_nxt;
    logic                     busy, cart_we;
    logic                     unused_ss;

    assign unused_ss = ^{ss_req, ss_wr, ss_data};
    assign cart_we   = enable & ce_cpu & cart_wr & ~cart_a15 & ~busy;

    // Register values after this cycle's cart write, before any savestate override
    always_comb begin
        rom_bank_w = rom_bank;
        ram_bank_w = ram_bank;
        ram_en_w   = ram_en;
        mode_w     = mode;
        if (cart_we) begin
            case (cart_addr[14:12])
                3'd0, 3'd1: ram_en_w = (cart_di[3:0] == 4'hA);
                3'd2: begin
                    for (int i = 0; i < ROM_BANK_BITS && i < 8; i++) rom_bank_w[i] = cart_di[i];
                end
                3'd3: begin
                    for (int i = 8; i < ROM_BANK_BITS; i++) rom_bank_w[i] = cart_di[i-8];
                end
                3'd4, 3'd5: ram_bank_w = cart_di[RAM_BANK_BITS-1:0];
                default:    mode_w = cart_di[0];
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            rom_bank <= ROM_BANK_BITS'(1);
            ram_bank <= '0;
            ram_en   <= 1'b0;
            mode     <= 1'b0;
        end else begin
            rom_bank <= rom_bank_nxt;
            ram_bank <= ram_bank_nxt;
            ram_en   <= ram_en_nxt;
            mode     <= mode_nxt;
        end
    end

    assign rom_eff   = (ZERO_REMAP != 0 && rom_bank == '0) ? ROM_BANK_BITS'(1) : rom_bank;
    assign rom_sel   = cart_addr[14] ? (rom_eff & rom_mask)
                     : (mode ? ({rom_bank[ROM_BANK_BITS-1:5], 5'b0} & rom_mask) : '0);
    assign mbc_addr    = {rom_sel, cart_addr[13:0]};
    assign cram_addr   = {ram_bank & ram_mask, cart_addr[12:0]};
    assign ram_enabled = ram_en & has_ram & enable;

`ifdef MAPPER_SAVESTATE_EN
    // state | meaning
    // IDLE  | no savestate activity, cart writes accepted
    // SAVE0 | word0 presented on ss_back
    // SAVE1 | word1 presented on ss_back
    // LOAD1 | word0 restored, waiting for word1 strobe
    typedef enum logic [1:0] {IDLE, SAVE0, SAVE1, LOAD1} state_t;

    state_t      state, state_nxt;
    logic [15:0] back_q, back_nxt, word0, word1;
    logic        valid_q, valid_nxt;

    // word0 snapshots the post-write bank so a write in the request cycle is captured
    assign word0 = 16'(rom_bank_w);
    assign word1 = {ram_en, mode, 6'b0, 8'(ram_bank)};

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state   <= IDLE;
            back_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            back_q  <= back_nxt;
            valid_q <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        back_nxt     = back_q;
        valid_nxt    = 1'b0;
        rom_bank_nxt = rom_bank_w;
        ram_bank_nxt = ram_bank_w;
        ram_en_nxt   = ram_en_w;
        mode_nxt     = mode_w;
        case (state)
            IDLE: begin
                if (ss_wr) begin
                    rom_bank_nxt = ss_data[ROM_BANK_BITS-1:0];
                    state_nxt    = LOAD1;
                end else if (ss_req) begin
                    back_nxt  = word0;
                    valid_nxt = 1'b1;
                    state_nxt = SAVE0;
                end
            end
            SAVE0: begin
                back_nxt  = word1;
                valid_nxt = 1'b1;
                state_nxt = SAVE1;
            end
            SAVE1: state_nxt = IDLE;
            LOAD1: begin
                if (ss_wr) begin
                    ram_en_nxt   = ss_data[15];
                    mode_nxt     = ss_data[14];
                    ram_bank_nxt = ss_data[RAM_BANK_BITS-1:0];
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign ss_back  = back_q;
    assign ss_valid = valid_q;
    assign ss_busy  = busy;
`else
    assign busy         = 1'b0;
    assign rom_bank_nxt = rom_bank_w;
    assign ram_bank_nxt = ram_bank_w;
    assign ram_en_nxt   = ram_en_w;
    assign mode_nxt     = mode_w;
    assign ss_back      = '0;
    assign ss_valid     = 1'b0;
    assign ss_busy      = 1'b0;
`endif

endmodule
